// File: rtl/slow_clock_pkg.sv
// Shared constants and helpers for the multi-channel slow-clock generator.
package slow_clock_pkg;

   localparam int          CNT_W_DEF       = 32;
   localparam int unsigned DEFAULT_DIV_DEF = 100000000;

   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/slow_clock_chan.sv
// One divider channel: counter, shadow/active divisor, toggle output and tick.
module slow_clock_chan
   import slow_clock_pkg::*;
#(
   parameter int          CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_data,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] active_div;
   logic [CNT_W-1:0] shadow_div;
   logic             stopped;
   logic             wrap;
   logic             apply;

   assign stopped = (active_div == '0);
   assign wrap    = en && !stopped && (cnt == active_div - CNT_W'(1));
   // A stopped channel picks up a new divisor on the very next enabled edge.
   assign apply   = pending && (sync || wrap || (en && stopped));

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         active_div <= CNT_W'(DEFAULT_DIV);
         shadow_div <= '0;
         pending    <= 1'b0;
         clk_out    <= 1'b0;
         tick       <= 1'b0;
      end else begin
         if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
         end else if (!en || stopped) begin
            if (en) cnt <= '0;
            tick <= 1'b0;
         end else if (wrap) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
         if (apply) begin
            active_div <= shadow_div;
            pending    <= 1'b0;
         end
         if (wr) begin
            shadow_div <= wr_data;
            pending    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/slow_clock_gen.sv
// Multi-channel slow-clock generator; SLOW_CLK_SYNC_EN adds the sync_in
// phase-restart port shared by all channels.
module slow_clock_gen
   import slow_clock_pkg::*;
#(
   parameter int          CHANNELS    = 4,
   parameter int          CNT_W       = CNT_W_DEF,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
   localparam int         SEL_W       = sel_w(CHANNELS)
) (
   input  logic                clk_in,
   input  logic                rst,
`ifdef SLOW_CLK_SYNC_EN
   input  logic                sync_in,
`endif
   input  logic [CHANNELS-1:0] en,
   input  logic                div_wr,
   input  logic [SEL_W-1:0]    div_sel,
   input  logic [CNT_W-1:0]    div_data,
   output logic [CHANNELS-1:0] div_pending,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic                led
);

   logic sync;

`ifdef SLOW_CLK_SYNC_EN
   assign sync = sync_in;
`else
   assign sync = 1'b0;
`endif

   // Selects at or beyond CHANNELS match no channel and are dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      slow_clock_chan #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk_in  (clk_in),
         .rst     (rst),
         .en      (en[i]),
         .sync    (sync),
         .wr      (div_wr && (div_sel == SEL_W'(i))),
         .wr_data (div_data),
         .pending (div_pending[i]),
         .clk_out (clk_out[i]),
         .tick    (tick[i])
      );
   end

   assign led = clk_out[0];

endmodule
